zap_memory_main: RTL

Memory stage pipeline register between the ALU stage and zap_register_file writeback.
- Captures ALU results, flags and exception indicators.
- Aligns, rotates or extends load data returned by the data memory.
- Presents one registered instruction per cycle to writeback via o_dav_ff.
- Holds on data stall; flushes on clear from writeback.

---
 rtl/zap_memory_main_pkg.sv | 34 +++
 rtl/zap_memory_main_if.sv | 9 +
 rtl/zap_mem_load_align.sv | 52 +++++
 rtl/zap_memory_main.sv | 121 ++++++++++++
 4 files changed

// File: rtl/zap_memory_main_pkg.sv
// Shared constants and size-select decode for the memory stage.
// Size decode priority: sbyte > ubyte > shalf > uhalf > word.
package zap_memory_main_pkg;

  localparam int PHY_REGS = 46;
  localparam int IW       = $clog2(PHY_REGS);
  localparam int FLAG_WDT = 32;

  typedef enum logic [2:0] {
    SZ_WORD  = 3'd0,
    SZ_UHALF = 3'd1,
    SZ_SHALF = 3'd2,
    SZ_UBYTE = 3'd3,
    SZ_SBYTE = 3'd4
  } size_sel_t;

  function automatic size_sel_t decode_size(input logic sbyte, input logic ubyte,
                                            input logic shalf, input logic uhalf);
    if (sbyte)      return SZ_SBYTE;
    else if (ubyte) return SZ_UBYTE;
    else if (shalf) return SZ_SHALF;
    else if (uhalf) return SZ_UHALF;
    else            return SZ_WORD;
  endfunction

  function automatic logic is_misaligned(input size_sel_t sel, input logic [1:0] lsb);
    case (sel)
      SZ_SBYTE, SZ_UBYTE: return 1'b0;
      SZ_SHALF, SZ_UHALF: return lsb[0];
      default:            return (lsb != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/zap_memory_main_if.sv
// Data-memory response bundle seen by the memory stage.
interface zap_memory_main_if;
  logic        i_data_stall;
  logic        i_data_abort;
  logic [31:0] i_mem_rd_data;

  modport master (output i_data_stall, output i_data_abort, output i_mem_rd_data);
  modport slave  (input  i_data_stall, input  i_data_abort, input  i_mem_rd_data);
endinterface

// File: rtl/zap_mem_load_align.sv
// Combinational load aligner: lane select, sign/zero extend, unaligned word rotate.
// With MEM_ALIGN_CHECK_EN defined, words are passed through unrotated (misalignment aborts).
module zap_mem_load_align
  import zap_memory_main_pkg::*;
(
  input  logic [31:0] i_rd_data,
  input  logic [1:0]  i_addr_lsb,
  input  logic        i_sbyte,
  input  logic        i_ubyte,
  input  logic        i_shalf,
  input  logic        i_uhalf,
  output logic [31:0] o_data
);

  size_sel_t   w_sel;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_sel = decode_size(i_sbyte, i_ubyte, i_shalf, i_uhalf);
    case (i_addr_lsb)
      2'd0:    w_byte = i_rd_data[7:0];
      2'd1:    w_byte = i_rd_data[15:8];
      2'd2:    w_byte = i_rd_data[23:16];
      default: w_byte = i_rd_data[31:24];
    endcase
    w_half = i_addr_lsb[1] ? i_rd_data[31:16] : i_rd_data[15:0];
  end

  always_comb begin
    o_data = i_rd_data;
    case (w_sel)
      SZ_SBYTE: o_data = {{24{w_byte[7]}}, w_byte};
      SZ_UBYTE: o_data = {24'd0, w_byte};
      SZ_SHALF: o_data = {{16{w_half[15]}}, w_half};
      SZ_UHALF: o_data = {16'd0, w_half};
      default: begin
`ifdef MEM_ALIGN_CHECK_EN
        o_data = i_rd_data;
`else
        case (i_addr_lsb)
          2'd0:    o_data = i_rd_data;
          2'd1:    o_data = {i_rd_data[7:0],  i_rd_data[31:8]};
          2'd2:    o_data = {i_rd_data[15:0], i_rd_data[31:16]};
          default: o_data = {i_rd_data[23:0], i_rd_data[31:24]};
        endcase
`endif
      end
    endcase
  end

endmodule

// File: rtl/zap_memory_main.sv
// Memory stage pipeline register between ALU and writeback; clear beats stall beats capture.
// Optional MEM_ALIGN_CHECK_EN: misaligned half/word accesses raise a data abort.
module zap_memory_main
  import zap_memory_main_pkg::*;
#(
  parameter int PHY_REGS = 46,
  parameter int FLAG_WDT = 32
)(
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_clear_from_writeback,
  zap_memory_main_if.slave            i_dmem,
  input  logic                        i_dav_ff,
  input  logic [31:0]                 i_alu_result_ff,
  input  logic [FLAG_WDT-1:0]         i_flags_ff,
  input  logic                        i_flag_update_ff,
  input  logic [$clog2(PHY_REGS)-1:0] i_destination_index_ff,
  input  logic [$clog2(PHY_REGS)-1:0] i_mem_srcdest_index_ff,
  input  logic                        i_mem_load_ff,
  input  logic                        i_mem_access_ff,
  input  logic                        i_sbyte_ff,
  input  logic                        i_ubyte_ff,
  input  logic                        i_shalf_ff,
  input  logic                        i_uhalf_ff,
  input  logic [1:0]                  i_mem_address_lsb_ff,
  input  logic [31:0]                 i_pc_plus_8_ff,
  input  logic                        i_irq_ff,
  input  logic                        i_fiq_ff,
  input  logic                        i_instr_abt_ff,
  input  logic                        i_swi_ff,
  input  logic                        i_und_ff,
  output logic                        o_dav_ff,
  output logic [31:0]                 o_alu_result_ff,
  output logic [FLAG_WDT-1:0]         o_flags_ff,
  output logic                        o_flag_update_ff,
  output logic [$clog2(PHY_REGS)-1:0] o_destination_index_ff,
  output logic [$clog2(PHY_REGS)-1:0] o_mem_srcdest_index_ff,
  output logic                        o_mem_load_ff,
  output logic [31:0]                 o_mem_rd_data_ff,
  output logic [31:0]                 o_pc_plus_8_ff,
  output logic                        o_irq_ff,
  output logic                        o_fiq_ff,
  output logic                        o_instr_abt_ff,
  output logic                        o_swi_ff,
  output logic                        o_und_ff,
  output logic                        o_data_abt_ff
);

  logic [31:0] w_aligned;
  logic        w_misalign;
  logic        w_abort;

  zap_mem_load_align u_align (
    .i_rd_data  (i_dmem.i_mem_rd_data),
    .i_addr_lsb (i_mem_address_lsb_ff),
    .i_sbyte    (i_sbyte_ff),
    .i_ubyte    (i_ubyte_ff),
    .i_shalf    (i_shalf_ff),
    .i_uhalf    (i_uhalf_ff),
    .o_data     (w_aligned)
  );

  always_comb begin
`ifdef MEM_ALIGN_CHECK_EN
    w_misalign = is_misaligned(decode_size(i_sbyte_ff, i_ubyte_ff, i_shalf_ff, i_uhalf_ff),
                               i_mem_address_lsb_ff);
`else
    w_misalign = 1'b0;
`endif
    w_abort = i_dav_ff & i_mem_access_ff & (i_dmem.i_data_abort | w_misalign);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_dav_ff               <= 1'b0;
      o_alu_result_ff        <= '0;
      o_flags_ff             <= '0;
      o_flag_update_ff       <= 1'b0;
      o_destination_index_ff <= '0;
      o_mem_srcdest_index_ff <= '0;
      o_mem_load_ff          <= 1'b0;
      o_mem_rd_data_ff       <= '0;
      o_pc_plus_8_ff         <= '0;
      o_irq_ff               <= 1'b0;
      o_fiq_ff               <= 1'b0;
      o_instr_abt_ff         <= 1'b0;
      o_swi_ff               <= 1'b0;
      o_und_ff               <= 1'b0;
      o_data_abt_ff          <= 1'b0;
    end else if (i_clear_from_writeback) begin
      // Flush kills control/exception state only; data fields are don't-care once dav drops.
      o_dav_ff         <= 1'b0;
      o_mem_load_ff    <= 1'b0;
      o_flag_update_ff <= 1'b0;
      o_irq_ff         <= 1'b0;
      o_fiq_ff         <= 1'b0;
      o_instr_abt_ff   <= 1'b0;
      o_swi_ff         <= 1'b0;
      o_und_ff         <= 1'b0;
      o_data_abt_ff    <= 1'b0;
    end else if (!i_dmem.i_data_stall) begin
      o_dav_ff               <= i_dav_ff;
      o_alu_result_ff        <= i_alu_result_ff;
      o_flags_ff             <= i_flags_ff;
      o_flag_update_ff       <= i_flag_update_ff;
      o_destination_index_ff <= i_destination_index_ff;
      o_mem_srcdest_index_ff <= i_mem_srcdest_index_ff;
      o_mem_load_ff          <= i_dav_ff & i_mem_load_ff & ~w_abort;
      o_pc_plus_8_ff         <= i_pc_plus_8_ff;
      o_irq_ff               <= i_dav_ff & i_irq_ff;
      o_fiq_ff               <= i_dav_ff & i_fiq_ff;
      o_instr_abt_ff         <= i_dav_ff & i_instr_abt_ff;
      o_swi_ff               <= i_dav_ff & i_swi_ff;
      o_und_ff               <= i_dav_ff & i_und_ff;
      o_data_abt_ff          <= w_abort;
      if (i_dav_ff & i_mem_load_ff)
        o_mem_rd_data_ff <= w_aligned;
    end
  end

endmodule
